stage_wb: RTL and testbench
===========================

STAGE_WB -- requirements
Module: stage_wb

Interface
REQ-001 SHALL have port CLK  in  1  system clock, all state on rising edge.
REQ-002 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port wb_en  in  1  MEM/WB latch enable (pipeline advance).
REQ-004 SHALL have port flush  in  1  insert bubble into MEM/WB latch.
REQ-005 SHALL have port valid_in  in  1  MEM-stage slot holds a real instruction.
REQ-006 SHALL have ports regWrite_in, memtoReg_in, jal_in, halt_in  in  1 each  MEM-stage control bits.
REQ-007 SHALL have port wsel_in  in  5  destination register from MEM stage.
REQ-008 SHALL have ports aluOut_in, dmemload_in, npc_in  in  32 each  ALU result, load data, next PC.
REQ-009 SHALL have port regWriteWB_out  out  1  register-file write enable to decode.
REQ-010 SHALL have port regSelWB_out  out  5  register-file write select to decode.
REQ-011 SHALL have port wdatWB_out  out  32  non-jal write data to decode.
REQ-012 SHALL have ports jalWB_out  out  1 and npcWB_out  out  32  link-write select and link value to decode.
REQ-013 SHALL have port halt_out  out  1  sticky processor halt.
REQ-014 SHALL have port instret_out  out  32  retired-instruction count.

Function
REQ-015 SHALL hold one MEM/WB latch: valid, regWrite, memtoReg, jal, halt, wsel, aluOut, dmemload, npc.
REQ-016 On rising edge, priority: halted (hold all) > flush (valid and all control bits 0, data 0) > wb_en (capture all inputs) > hold.
REQ-017 Latency: inputs captured at edge N appear on outputs after edge N; outputs combinational from latch only, no input-to-output path.
REQ-018 regSelWB_out SHALL be 31 when latched jal=1, else latched wsel.
REQ-019 wdatWB_out SHALL be latched dmemload when memtoReg=1, else latched aluOut.
REQ-020 jalWB_out = valid & jal; npcWB_out = latched npc.
REQ-021 regWriteWB_out SHALL be valid & (regWrite | jal) & (regSelWB_out != 0); writes to $0 suppressed.
REQ-022 Internal halted flag set on the edge that captures valid_in=1 & halt_in=1; halt_out = halted; cleared only by reset.
REQ-023 After halted set, latch frozen; regWriteWB_out SHALL be 0 from the next cycle onward (halt instruction itself never writes).
REQ-024 flush and wb_en both 1 in same cycle: flush wins, nothing counted.

Reset
REQ-025 nRST low SHALL immediately clear latch (valid 0, all control 0, data 0), halted 0, counter 0.
REQ-026 Reset values: regWriteWB_out 0, regSelWB_out 0, wdatWB_out 0, jalWB_out 0, npcWB_out 0, halt_out 0, instret_out 0.
REQ-027 Reset asserted mid-capture or while halted SHALL override all; first capture allowed on first rising edge after nRST high.

Configuration
REQ-028 Macro STAGE_WB_INSTRET_EN defined: 32-bit counter increments on each edge with wb_en=1, flush=0, valid_in=1, halted=0 (halt instruction counts); wraps 0xFFFFFFFF -> 0.
REQ-029 Macro undefined: no counter logic, instret_out tied 0; all other behaviour identical.

Verification
REQ-030 Reset, then wb_en=1, valid_in=1, regWrite_in=1, memtoReg_in=0, wsel_in=5, aluOut_in=0x1234 -> after edge: regWriteWB_out=1, regSelWB_out=5, wdatWB_out=0x1234.
REQ-031 memtoReg_in=1, dmemload_in=0xDEADBEEF, aluOut_in=0x40 -> wdatWB_out=0xDEADBEEF; wsel_in=0, regWrite_in=1 -> regWriteWB_out=0.
REQ-032 jal_in=1, npc_in=0x0000_0104, wsel_in=0 -> regSelWB_out=31, jalWB_out=1, npcWB_out=0x104, regWriteWB_out=1.
REQ-033 wb_en=1 and flush=1 same edge with valid instruction -> regWriteWB_out=0, outputs 0, instret_out unchanged; wb_en=0 -> outputs held for 3 cycles.
REQ-034 halt_in=1 valid captured -> halt_out=1, regWriteWB_out=0; subsequent valid writes ignored for 10 cycles; nRST pulse mid-cycle -> halt_out=0 immediately.
REQ-035 With STAGE_WB_INSTRET_EN: force counter to 0xFFFFFFFF via 2^32-1 captures or backdoor, one more valid capture -> instret_out=0; without macro instret_out=0 throughout.

Source files
------------

// File: rtl/stage_wb_if.sv
// MEM/WB boundary bus for stage_wb.
// The master side (the MEM stage, or a bench standing in for it) drives the
// captured inputs and observes the writeback outputs. The slave side is the
// writeback stage itself.
interface stage_wb_if;
  // Pipeline control from the hazard unit
  logic        wb_en;
  logic        flush;

  // MEM-stage slot contents
  logic        valid_in;
  logic        regWrite_in;
  logic        memtoReg_in;
  logic        jal_in;
  logic        halt_in;
  logic [4:0]  wsel_in;
  logic [31:0] aluOut_in;
  logic [31:0] dmemload_in;
  logic [31:0] npc_in;

  // Writeback results toward decode / register file
  logic        regWriteWB_out;
  logic [4:0]  regSelWB_out;
  logic [31:0] wdatWB_out;
  logic        jalWB_out;
  logic [31:0] npcWB_out;
  logic        halt_out;
  logic [31:0] instret_out;

  modport master (
    output wb_en, flush, valid_in, regWrite_in, memtoReg_in, jal_in, halt_in,
           wsel_in, aluOut_in, dmemload_in, npc_in,
    input  regWriteWB_out, regSelWB_out, wdatWB_out, jalWB_out, npcWB_out,
           halt_out, instret_out
  );

  modport slave (
    input  wb_en, flush, valid_in, regWrite_in, memtoReg_in, jal_in, halt_in,
           wsel_in, aluOut_in, dmemload_in, npc_in,
    output regWriteWB_out, regSelWB_out, wdatWB_out, jalWB_out, npcWB_out,
           halt_out, instret_out
  );
endinterface

// File: rtl/stage_wb.sv
// stage_wb: MEM/WB pipeline latch plus writeback select logic.
// Holds one instruction slot, produces the register-file write port for
// decode, and keeps a sticky halt flag that freezes the stage until reset.
// Optional feature: define STAGE_WB_INSTRET_EN to build the 32-bit
// retired-instruction counter. Undefined, instret_out is constant zero.
module stage_wb (
  input  logic      CLK,
  input  logic      nRST,
  stage_wb_if.slave wb
);

  // Contents of the MEM/WB latch
  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memtoReg;
    logic        jal;
    logic        halt;
    logic [4:0]  wsel;
    logic [31:0] aluOut;
    logic [31:0] dmemload;
    logic [31:0] npc;
  } wb_latch_t;

  localparam logic [4:0] LINK_REG = 5'd31;

  wb_latch_t latch_q, latch_d;
  logic      halted_q, halted_d;
  logic [4:0] sel_w;

  // Latch update: halted freezes everything, flush inserts a bubble,
  // otherwise wb_en captures the MEM slot. Halt is flagged on its capture.
  always_comb begin
    latch_d  = latch_q;
    halted_d = halted_q;
    if (halted_q) begin
      latch_d  = latch_q;
    end else if (wb.flush) begin
      latch_d  = '0;
    end else if (wb.wb_en) begin
      latch_d.valid    = wb.valid_in;
      latch_d.regWrite = wb.regWrite_in;
      latch_d.memtoReg = wb.memtoReg_in;
      latch_d.jal      = wb.jal_in;
      latch_d.halt     = wb.halt_in;
      latch_d.wsel     = wb.wsel_in;
      latch_d.aluOut   = wb.aluOut_in;
      latch_d.dmemload = wb.dmemload_in;
      latch_d.npc      = wb.npc_in;
      if (wb.valid_in && wb.halt_in) begin
        halted_d = 1'b1;
      end
    end
  end

  // Latch and halt flag registers; reset clears them immediately
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      latch_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      latch_q  <= latch_d;
      halted_q <= halted_d;
    end
  end

`ifdef STAGE_WB_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  // A valid instruction retires when it is captured; the halt itself counts.
  // Natural 32-bit wrap.
  always_comb begin
    instret_d = instret_q;
    if (!halted_q && !wb.flush && wb.wb_en && wb.valid_in) begin
      instret_d = instret_q + 32'd1;
    end
  end

  // Retired-instruction counter register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign wb.instret_out = instret_q;
`else
  assign wb.instret_out = '0;
`endif

  // Writeback outputs, driven from the latch only. A jal always targets the
  // link register; writes aimed at $0 are dropped; a halt never writes and
  // nothing writes once the stage is frozen.
  always_comb begin
    sel_w             = latch_q.jal ? LINK_REG : latch_q.wsel;
    wb.regSelWB_out   = sel_w;
    wb.wdatWB_out     = latch_q.memtoReg ? latch_q.dmemload : latch_q.aluOut;
    wb.jalWB_out      = latch_q.valid & latch_q.jal;
    wb.npcWB_out      = latch_q.npc;
    wb.halt_out       = halted_q;
    wb.regWriteWB_out = latch_q.valid
                      & (latch_q.regWrite | latch_q.jal)
                      & (sel_w != 5'd0)
                      & ~latch_q.halt
                      & ~halted_q;
  end

endmodule

// File: tb/tb_stage_wb.sv
// Bench for stage_wb: directed vectors with hand-computed expectations.
// The driver pushes each expected response into a queue after the capturing
// edge; an independent monitor pops and compares on the following falling edge.
module tb_stage_wb;

  logic CLK;
  logic nRST;

  stage_wb_if bus ();

  stage_wb dut (
    .CLK  (CLK),
    .nRST (nRST),
    .wb   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        wb_en, flush, valid, rw, mtr, jal, halt;
    logic [4:0]  wsel;
    logic [31:0] alu, dmem, npc;
    logic        e_rw;
    logic [4:0]  e_sel;
    logic [31:0] e_wdat;
    logic        e_jal;
    logic [31:0] e_npc;
    logic        e_halt;
    logic [31:0] e_cnt;
    int          id;
  } vec_t;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  task automatic check32(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", name, id, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_instret(input logic [31:0] cnt);
`ifdef STAGE_WB_INSTRET_EN
    return cnt;
`else
    return 32'd0 & cnt;
`endif
  endfunction

  function automatic vec_t mk(
    input logic wb_en, input logic flush, input logic valid, input logic rw,
    input logic mtr, input logic jal, input logic halt, input logic [4:0] wsel,
    input logic [31:0] alu, input logic [31:0] dmem, input logic [31:0] npc,
    input logic e_rw, input logic [4:0] e_sel, input logic [31:0] e_wdat,
    input logic e_jal, input logic [31:0] e_npc, input logic e_halt,
    input logic [31:0] e_cnt);
    vec_t v;
    v.wb_en = wb_en; v.flush = flush; v.valid = valid; v.rw = rw;
    v.mtr = mtr; v.jal = jal; v.halt = halt; v.wsel = wsel;
    v.alu = alu; v.dmem = dmem; v.npc = npc;
    v.e_rw = e_rw; v.e_sel = e_sel; v.e_wdat = e_wdat; v.e_jal = e_jal;
    v.e_npc = e_npc; v.e_halt = e_halt; v.e_cnt = e_cnt; v.id = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.wb_en       = v.wb_en;
    bus.flush       = v.flush;
    bus.valid_in    = v.valid;
    bus.regWrite_in = v.rw;
    bus.memtoReg_in = v.mtr;
    bus.jal_in      = v.jal;
    bus.halt_in     = v.halt;
    bus.wsel_in     = v.wsel;
    bus.aluOut_in   = v.alu;
    bus.dmemload_in = v.dmem;
    bus.npc_in      = v.npc;
  endtask

  // Apply one vector for one cycle and queue its expected result
  task automatic run_vec(input vec_t v);
    vec_t e;
    @(negedge CLK);
    drive(v);
    @(posedge CLK);
    #1;
    e = v;
    vec_id++;
    e.id = vec_id;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_regWrite"}, 0, {31'd0, bus.regWriteWB_out}, 32'd0);
    check32({tag, "_regSel"},   0, {27'd0, bus.regSelWB_out},   32'd0);
    check32({tag, "_wdat"},     0, bus.wdatWB_out,              32'd0);
    check32({tag, "_jal"},      0, {31'd0, bus.jalWB_out},      32'd0);
    check32({tag, "_npc"},      0, bus.npcWB_out,               32'd0);
    check32({tag, "_halt"},     0, {31'd0, bus.halt_out},       32'd0);
    check32({tag, "_instret"},  0, bus.instret_out,             32'd0);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  initial begin
    vec_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check32("regWriteWB", e.id, {31'd0, bus.regWriteWB_out}, {31'd0, e.e_rw});
        check32("regSelWB",   e.id, {27'd0, bus.regSelWB_out},   {27'd0, e.e_sel});
        check32("wdatWB",     e.id, bus.wdatWB_out,              e.e_wdat);
        check32("jalWB",      e.id, {31'd0, bus.jalWB_out},      {31'd0, e.e_jal});
        check32("npcWB",      e.id, bus.npcWB_out,               e.e_npc);
        check32("halt",       e.id, {31'd0, bus.halt_out},       {31'd0, e.e_halt});
        check32("instret",    e.id, bus.instret_out,             exp_instret(e.e_cnt));
        $display("vec%0d: rw=%0b sel=%0d wdat=0x%08h jal=%0b npc=0x%08h halt=%0b instret=%0d",
                 e.id, bus.regWriteWB_out, bus.regSelWB_out, bus.wdatWB_out,
                 bus.jalWB_out, bus.npcWB_out, bus.halt_out, bus.instret_out);
      end
    end
  end

  // Stimulus
  initial begin
    // Reset held low across edges while a capture is being offered
    nRST = 1'b0;
    drive(mk(1,0,1,1,0,0,0,5'd5,32'hABC,32'h0,32'h10, 0,0,0,0,0,0,0));
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    nRST = 1'b1;

    //          wb fl v rw mt jl ht wsel   alu            dmem           npc           e_rw e_sel  e_wdat         e_jal e_npc      e_h cnt
    run_vec(mk(1, 0, 1, 1, 0, 0, 0, 5'd5,  32'h1234,      32'h0,         32'h0,        1,   5'd5,  32'h1234,      0,    32'h0,     0,  1));
    run_vec(mk(1, 0, 1, 1, 1, 0, 0, 5'd0,  32'h40,        32'hDEADBEEF,  32'h0,        0,   5'd0,  32'hDEADBEEF,  0,    32'h0,     0,  2));
    run_vec(mk(1, 0, 1, 0, 0, 1, 0, 5'd0,  32'h8,         32'h0,         32'h104,      1,   5'd31, 32'h8,         1,    32'h104,   0,  3));
    run_vec(mk(1, 1, 1, 1, 0, 1, 0, 5'd7,  32'h99,        32'h0,         32'h4,        0,   5'd0,  32'h0,         0,    32'h0,     0,  3));
    run_vec(mk(1, 0, 1, 1, 0, 0, 0, 5'd9,  32'hAAAA,      32'h0,         32'h200,      1,   5'd9,  32'hAAAA,      0,    32'h200,   0,  4));
    for (int i = 0; i < 3; i++)
      run_vec(mk(0, 0, 1, 1, 0, 0, 0, 5'd3, 32'h5555,     32'h0,         32'h8,        1,   5'd9,  32'hAAAA,      0,    32'h200,   0,  4));
    run_vec(mk(1, 0, 0, 1, 0, 0, 0, 5'd4,  32'h77,        32'h0,         32'h0,        0,   5'd4,  32'h77,        0,    32'h0,     0,  4));
    run_vec(mk(0, 1, 1, 1, 0, 0, 0, 5'd4,  32'h77,        32'h0,         32'h0,        0,   5'd0,  32'h0,         0,    32'h0,     0,  4));
    run_vec(mk(1, 0, 1, 1, 0, 0, 1, 5'd6,  32'h11,        32'h0,         32'h300,      0,   5'd6,  32'h11,        0,    32'h300,   1,  5));
    for (int i = 0; i < 10; i++)
      run_vec(mk(1, (i == 4), 1, 1, 0, (i == 7), 0, 5'd2, 32'hFFFF, 32'h0, 32'h8,
                 0, 5'd6, 32'h11, 0, 32'h300, 1, 5));

    // Asynchronous reset pulse between edges while halted
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1 check_all_zero("midreset");
    #1 nRST = 1'b1;

    run_vec(mk(1, 0, 1, 1, 0, 0, 0, 5'd10, 32'hCAFE,      32'h0,         32'h0,        1,   5'd10, 32'hCAFE,      0,    32'h0,     0,  1));
    run_vec(mk(1, 0, 0, 0, 0, 1, 0, 5'd3,  32'h0,         32'h0,         32'h44,       0,   5'd31, 32'h0,         0,    32'h44,    0,  1));
    run_vec(mk(1, 0, 1, 0, 1, 1, 0, 5'd8,  32'h2,         32'h1357,      32'h48,       1,   5'd31, 32'h1357,      1,    32'h48,    0,  2));

    // Let the monitor drain
    repeat (3) @(negedge CLK);
    check32("queue_drained", 0, exp_q.size(), 32'd0);

`ifdef STAGE_WB_INSTRET_EN
    // Counter wrap: preload all-ones through a backdoor, then one capture
    @(negedge CLK);
    drive(mk(0,0,0,0,0,0,0,5'd0,32'h0,32'h0,32'h0, 0,0,0,0,0,0,0));
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    check32("instret_preload", 0, bus.instret_out, 32'hFFFF_FFFF);
    @(negedge CLK);
    drive(mk(1,0,1,1,0,0,0,5'd1,32'h1,32'h0,32'h0, 0,0,0,0,0,0,0));
    @(posedge CLK);
    #1;
    check32("instret_wrap", 0, bus.instret_out, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
